gmii_video_aux_rx: RTL and testbench
====================================

Name: gmii_video_aux_rx

Overview:
- GMII receive-side depacketizer for the HDMI-over-Ethernet link; sits between the PHY RX pins and the receive FIFOs.
- Parses our video and aux (audio) Ethernet frames from `rxd`/`rx_dv`.
- Emits 29-bit video words with a write strobe, and 25-bit aux words with their own write strobe.
- No CRC check; frames are filtered by EtherType and source id only.

Parameters:
- ETHTYPE, 16'h0800, required EtherType; frames carrying any other value are dropped.

Ports:
- clk125  in  1  GMII RX clock, 125 MHz; the only clock.
- sys_rst  in  1  reset, asynchronous, active-high.
- id  in  1  local node id; frames whose source id equals id are dropped (loopback rejection).
- rxd  in  8  GMII receive data.
- rx_dv  in  1  GMII receive data valid.
- datain  out  29  video word: [28]=start-of-line flag, [27]=0, [26:16]=line number, [15:0]=pixel.
- recv_en  out  1  one-cycle write strobe for datain.
- packet_en  out  1  high while an accepted frame is being received.
- aux_data_in  out  25  aux word: {pos[15:0], aux[8:0]}.
- aux_wr_en  out  1  one-cycle write strobe for aux_data_in.

Behaviour:
- Input registering: rxd and rx_dv are registered once; all parsing runs on the registered copies.
- Output timing: all outputs are registered. A strobe occurs 2 clk125 cycles after the last byte of its word is on rxd.
- Reset: all outputs go to 0, state to IDLE, counters to 0, immediately on sys_rst assertion.
- Frame layout, all multi-byte fields MSB first:
  - preamble: 0x55 repeated (any count ≥1), then SFD 0xD5;
  - 6-byte destination MAC and 6-byte source MAC (both ignored);
  - 2-byte EtherType;
  - byte P0: bit7 = type (0 video, 1 aux), bit0 = source id, other bits ignored.
- Video frame:
  - P1–P2 = line number (low 11 bits used).
  - P3–P4 = start pixel index.
  - P5–P6 = pixel count N.
  - Then N pixels, 2 bytes each.
- Aux frame:
  - P1 = entry count M (0–255).
  - Then M entries, 4 bytes each. The top 7 bits of each entry are discarded; the low 25 bits form aux_data_in.
- States and transitions:
  - IDLE: on rx_dv with 0x55, go to PREAMBLE.
  - PREAMBLE: 0x55 stays; 0xD5 goes to HEADER; any other byte goes to DROP.
  - HEADER: 14 bytes. EtherType ≠ ETHTYPE goes to DROP.
  - TYPE: source id == id goes to DROP. Otherwise go to VID_HDR or AUX_HDR by the type bit.
  - VID_HDR: 6 bytes, then VID_DATA; if N == 0, go to DROP instead.
  - VID_DATA: for each pixel, `datain = {sol, 1'b0, line, pixel}` and recv_en pulses once on the second byte. sol = 1 only for the first pixel of a frame whose start index is 0. After N pixels, go to DROP.
  - AUX_HDR: 1 byte, then AUX_DATA; if M == 0, go to DROP instead.
  - AUX_DATA: aux_wr_en pulses on every 4th byte. After M entries, go to DROP.
  - DROP: ignore bytes until rx_dv goes low.
- Trailing bytes: padding and FCS after the counted payload are ignored.
- Abort on rx_dv low: in any state, the state machine returns to IDLE on the next cycle. A partially assembled pixel or entry is discarded, with no strobe.
- packet_en: set when TYPE accepts a frame; cleared when rx_dv goes low or on reset.
- Strobe exclusivity: recv_en and aux_wr_en are never high in the same cycle.
- Data hold: datain and aux_data_in hold their last value between strobes.
- Back-to-back frames: a new frame may start as soon as rx_dv rises again; no inter-frame gap is required by the parser.

Test Plan:
- Video, accepted: id=0, frame with source id 1, line 5, start 0, N=3, pixels 0x1234, 0x5678, 0x9ABC.
  -> three recv_en pulses with datain = 0x10051234, 0x00055678, 0x00059ABC; packet_en high until rx_dv falls.
- Aux, accepted: M=2, entries 0x0000_0201 and 0x01FF_FFFF.
  -> aux_wr_en twice with aux_data_in = 0x0000201, 0x1FFFFFF; recv_en stays 0.
- Rejection: frame with source id equal to id, and a separate frame with EtherType 0x88B5.
  -> no strobes, packet_en stays 0.
- Truncation: video N=4, rx_dv drops after 5 pixel bytes.
  -> exactly 2 recv_en pulses; the next valid frame parses normally.
- Reset mid-frame: assert sys_rst during VID_DATA.
  -> all outputs 0 immediately; a frame sent after release yields correct words.
- Bad preamble: 0x55 0x55 0x12 ... -> frame dropped, no strobes.

Source files
------------

// File: rtl/gmii_video_aux_rx.sv
`default_nettype none
// ============================================================================
//  Module      : gmii_video_aux_rx
//  Description : GMII receive depacketizer for the HDMI-over-Ethernet link.
//                Filters frames by EtherType and source id, then emits video
//                words (line/pixel) and aux words, each with a write strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module gmii_video_aux_rx #(
   parameter logic [15:0] ETHTYPE = 16'h0800
) (
   input  logic        clk125,
   input  logic        sys_rst,
   input  logic        id,
   input  logic [7:0]  rxd,
   input  logic        rx_dv,
   output logic [28:0] datain,
   output logic        recv_en,
   output logic        packet_en,
   output logic [24:0] aux_data_in,
   output logic        aux_wr_en
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_PREAMBLE = 4'd1,
      S_HEADER   = 4'd2,
      S_TYPE     = 4'd3,
      S_VID_HDR  = 4'd4,
      S_VID_DATA = 4'd5,
      S_AUX_HDR  = 4'd6,
      S_AUX_DATA = 4'd7,
      S_DROP     = 4'd8
   } state_t;

   // Registered copies of the PHY pins; all parsing works on these.
   logic [7:0]  d_q;
   logic        dv_q;

   state_t      state, state_n;
   logic [15:0] cnt, cnt_n;         // header byte index / payload element index
   logic [15:0] limit, limit_n;     // payload element count (N or M)
   logic [16:0] acc, acc_n;         // byte history, enough for a 25-bit aux word
   logic [10:0] line, line_n;
   logic        sol, sol_n;         // next pixel is the first of a line
   logic [1:0]  phase, phase_n;     // byte position within a pixel or entry
   logic [28:0] datain_n;
   logic        recv_en_n;
   logic        packet_en_n;
   logic [24:0] aux_data_in_n;
   logic        aux_wr_en_n;

   // Capture the GMII inputs once per cycle.
   always_ff @(posedge clk125 or posedge sys_rst) begin
      if (sys_rst) begin
         d_q  <= 8'h00;
         dv_q <= 1'b0;
      end else begin
         d_q  <= rxd;
         dv_q <= rx_dv;
      end
   end

   // State, parse context and output registers.
   always_ff @(posedge clk125 or posedge sys_rst) begin
      if (sys_rst) begin
         state       <= S_IDLE;
         cnt         <= 16'd0;
         limit       <= 16'd0;
         acc         <= 17'd0;
         line        <= 11'd0;
         sol         <= 1'b0;
         phase       <= 2'd0;
         datain      <= 29'd0;
         recv_en     <= 1'b0;
         packet_en   <= 1'b0;
         aux_data_in <= 25'd0;
         aux_wr_en   <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         limit       <= limit_n;
         acc         <= acc_n;
         line        <= line_n;
         sol         <= sol_n;
         phase       <= phase_n;
         datain      <= datain_n;
         recv_en     <= recv_en_n;
         packet_en   <= packet_en_n;
         aux_data_in <= aux_data_in_n;
         aux_wr_en   <= aux_wr_en_n;
      end
   end

   // Next-state and next-output decode; strobes default low every cycle.
   always_comb begin
      state_n       = state;
      cnt_n         = cnt;
      limit_n       = limit;
      acc_n         = acc;
      line_n        = line;
      sol_n         = sol;
      phase_n       = phase;
      datain_n      = datain;
      recv_en_n     = 1'b0;
      packet_en_n   = packet_en;
      aux_data_in_n = aux_data_in;
      aux_wr_en_n   = 1'b0;

      if (!dv_q) begin
         // End of frame or abort: any half-built pixel/entry is abandoned.
         state_n     = S_IDLE;
         packet_en_n = 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (d_q == 8'h55) state_n = S_PREAMBLE;
            end
            S_PREAMBLE: begin
               cnt_n = 16'd0;
               if (d_q == 8'hD5)      state_n = S_HEADER;
               else if (d_q != 8'h55) state_n = S_DROP;
            end
            S_HEADER: begin
               acc_n = {acc[8:0], d_q};
               cnt_n = cnt + 16'd1;
               if (cnt == 16'd13) begin
                  cnt_n = 16'd0;
                  if ({acc[7:0], d_q} != ETHTYPE) state_n = S_DROP;
                  else                            state_n = S_TYPE;
               end
            end
            S_TYPE: begin
               cnt_n = 16'd0;
               if (d_q[0] == id) begin
                  state_n = S_DROP;
               end else begin
                  packet_en_n = 1'b1;
                  state_n     = d_q[7] ? S_AUX_HDR : S_VID_HDR;
               end
            end
            S_VID_HDR: begin
               acc_n = {acc[8:0], d_q};
               cnt_n = cnt + 16'd1;
               case (cnt)
                  16'd1: line_n = {acc[2:0], d_q};
                  16'd3: sol_n  = ({acc[7:0], d_q} == 16'd0);
                  16'd5: begin
                     limit_n = {acc[7:0], d_q};
                     cnt_n   = 16'd0;
                     phase_n = 2'd0;
                     state_n = ({acc[7:0], d_q} == 16'd0) ? S_DROP : S_VID_DATA;
                  end
                  default: ;
               endcase
            end
            S_VID_DATA: begin
               acc_n = {acc[8:0], d_q};
               if (phase[0] == 1'b0) begin
                  phase_n = 2'd1;
               end else begin
                  phase_n   = 2'd0;
                  datain_n  = {sol, 1'b0, line, acc[7:0], d_q};
                  recv_en_n = 1'b1;
                  sol_n     = 1'b0;
                  cnt_n     = cnt + 16'd1;
                  if (cnt + 16'd1 == limit) state_n = S_DROP;
               end
            end
            S_AUX_HDR: begin
               limit_n = {8'h00, d_q};
               cnt_n   = 16'd0;
               phase_n = 2'd0;
               state_n = (d_q == 8'h00) ? S_DROP : S_AUX_DATA;
            end
            S_AUX_DATA: begin
               acc_n   = {acc[8:0], d_q};
               phase_n = phase + 2'd1;
               if (phase == 2'd3) begin
                  // Top 7 bits of the 32-bit entry fall off the 17-bit history.
                  aux_data_in_n = {acc, d_q[7:0]};
                  aux_wr_en_n   = 1'b1;
                  cnt_n         = cnt + 16'd1;
                  if (cnt + 16'd1 == limit) state_n = S_DROP;
               end
            end
            S_DROP: ;
            default: state_n = S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gmii_video_aux_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gmii_video_aux_rx
//  Description : Directed self-checking bench for gmii_video_aux_rx.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gmii_video_aux_rx;

   logic        clk125 = 1'b0;
   logic        sys_rst;
   logic        id;
   logic [7:0]  rxd;
   logic        rx_dv;
   logic [28:0] datain;
   logic        recv_en;
   logic        packet_en;
   logic [24:0] aux_data_in;
   logic        aux_wr_en;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_cyc = 0;

   logic [28:0] vq[$];
   int          vcyc[$];
   logic [24:0] aq[$];
   int          both_cnt = 0;
   bit          pe_seen  = 1'b0;
   logic [7:0]  fr[$];

   gmii_video_aux_rx #(.ETHTYPE(16'h0800)) dut (
      .clk125      (clk125),
      .sys_rst     (sys_rst),
      .id          (id),
      .rxd         (rxd),
      .rx_dv       (rx_dv),
      .datain      (datain),
      .recv_en     (recv_en),
      .packet_en   (packet_en),
      .aux_data_in (aux_data_in),
      .aux_wr_en   (aux_wr_en)
   );

   always #4 clk125 = ~clk125;

   // Cycle counter for latency measurement.
   always @(posedge clk125) cyc <= cyc + 1;

   // Record strobes and packet_en activity, sampled mid-cycle.
   always @(negedge clk125) begin
      if (recv_en) begin
         vq.push_back(datain);
         vcyc.push_back(cyc);
      end
      if (aux_wr_en) aq.push_back(aux_data_in);
      if (recv_en && aux_wr_en) both_cnt++;
      if (packet_en) pe_seen = 1'b1;
   end

   task automatic clear_mon();
      vq.delete();
      vcyc.delete();
      aq.delete();
      both_cnt = 0;
      pe_seen  = 1'b0;
   endtask

   task automatic begin_frame(input logic [15:0] et, input logic [7:0] p0);
      fr.delete();
      repeat (3) fr.push_back(8'h55);
      fr.push_back(8'hD5);
      for (int i = 0; i < 12; i++) fr.push_back(8'(i + 1));
      fr.push_back(et[15:8]);
      fr.push_back(et[7:0]);
      fr.push_back(p0);
   endtask

   task automatic push16(input logic [15:0] v);
      fr.push_back(v[15:8]);
      fr.push_back(v[7:0]);
   endtask

   task automatic send_bytes(input int count);
      for (int i = 0; i < count && i < fr.size(); i++) begin
         @(negedge clk125);
         rxd      = fr[i];
         rx_dv    = 1'b1;
         last_cyc = cyc;
      end
   endtask

   task automatic end_frame(input int gap);
      @(negedge clk125);
      rx_dv = 1'b0;
      rxd   = 8'h00;
      repeat (gap - 1) @(negedge clk125);
   endtask

   task automatic test_reset();
      sys_rst = 1'b1;
      rx_dv   = 1'b0;
      rxd     = 8'h00;
      id      = 1'b0;
      #20;
      checks++;
      if ({datain, recv_en, packet_en, aux_data_in, aux_wr_en} !== 57'd0) begin
         failures++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {datain, recv_en, packet_en, aux_data_in, aux_wr_en});
      end
      @(negedge clk125);
      sys_rst = 1'b0;
      repeat (2) @(negedge clk125);
   endtask

   task automatic test_video();
      clear_mon();
      id = 1'b0;
      begin_frame(16'h0800, 8'h01);
      push16(16'd5); push16(16'd0); push16(16'd3);
      push16(16'h1234); push16(16'h5678); push16(16'h9ABC);
      send_bytes(fr.size());
      @(negedge clk125);
      checks++;
      if (packet_en !== 1'b1) begin
         failures++;
         $display("FAIL video_packet_en_high: got %b expected 1", packet_en);
      end
      end_frame(4);
      checks++;
      if (packet_en !== 1'b0) begin
         failures++;
         $display("FAIL video_packet_en_low: got %b expected 0", packet_en);
      end
      checks++;
      if (vq.size() != 3) begin
         failures++;
         $display("FAIL video_count: got %0d expected 3", vq.size());
      end
      if (vq.size() >= 3) begin
         checks++;
         if (vq[0] !== 29'h10051234) begin
            failures++;
            $display("FAIL video_word0: got %h expected 10051234", vq[0]);
         end
         checks++;
         if (vq[1] !== 29'h00055678) begin
            failures++;
            $display("FAIL video_word1: got %h expected 00055678", vq[1]);
         end
         checks++;
         if (vq[2] !== 29'h00059ABC) begin
            failures++;
            $display("FAIL video_word2: got %h expected 00059ABC", vq[2]);
         end
         checks++;
         if (vcyc[2] != last_cyc + 2) begin
            failures++;
            $display("FAIL video_latency: got %0d expected %0d", vcyc[2], last_cyc + 2);
         end
      end
      checks++;
      if (aq.size() != 0) begin
         failures++;
         $display("FAIL video_no_aux: got %0d expected 0", aq.size());
      end
   endtask

   task automatic test_aux();
      clear_mon();
      begin_frame(16'h0800, 8'h81);
      fr.push_back(8'd2);
      push16(16'h0000); push16(16'h0201);
      push16(16'h01FF); push16(16'hFFFF);
      send_bytes(fr.size());
      end_frame(4);
      checks++;
      if (aq.size() != 2) begin
         failures++;
         $display("FAIL aux_count: got %0d expected 2", aq.size());
      end
      if (aq.size() >= 2) begin
         checks++;
         if (aq[0] !== 25'h0000201) begin
            failures++;
            $display("FAIL aux_word0: got %h expected 0000201", aq[0]);
         end
         checks++;
         if (aq[1] !== 25'h1FFFFFF) begin
            failures++;
            $display("FAIL aux_word1: got %h expected 1FFFFFF", aq[1]);
         end
      end
      checks++;
      if (vq.size() != 0 || both_cnt != 0) begin
         failures++;
         $display("FAIL aux_no_video: got %0d/%0d expected 0/0", vq.size(), both_cnt);
      end
   endtask

   task automatic test_reject();
      clear_mon();
      begin_frame(16'h0800, 8'h00);
      push16(16'd5); push16(16'd0); push16(16'd1); push16(16'h4321);
      send_bytes(fr.size());
      end_frame(4);
      checks++;
      if (vq.size() != 0 || pe_seen) begin
         failures++;
         $display("FAIL reject_own_id: got %0d strobes pe=%b expected 0 pe=0", vq.size(), pe_seen);
      end
      clear_mon();
      begin_frame(16'h88B5, 8'h01);
      push16(16'd5); push16(16'd0); push16(16'd1); push16(16'h4321);
      send_bytes(fr.size());
      end_frame(4);
      checks++;
      if (vq.size() != 0 || pe_seen) begin
         failures++;
         $display("FAIL reject_ethtype: got %0d strobes pe=%b expected 0 pe=0", vq.size(), pe_seen);
      end
   endtask

   task automatic test_truncate();
      clear_mon();
      begin_frame(16'h0800, 8'h01);
      push16(16'd7); push16(16'd2); push16(16'd4);
      push16(16'h1111); push16(16'h2222); push16(16'h3333); push16(16'h4444);
      send_bytes(fr.size() - 3);
      end_frame(4);
      checks++;
      if (vq.size() != 2) begin
         failures++;
         $display("FAIL trunc_count: got %0d expected 2", vq.size());
      end
      if (vq.size() >= 2) begin
         checks++;
         if (vq[0] !== 29'h00071111 || vq[1] !== 29'h00072222) begin
            failures++;
            $display("FAIL trunc_words: got %h %h expected 00071111 00072222", vq[0], vq[1]);
         end
      end
      clear_mon();
      begin_frame(16'h0800, 8'h01);
      push16(16'd9); push16(16'd0); push16(16'd1); push16(16'hABCD);
      send_bytes(fr.size());
      end_frame(4);
      checks++;
      if (vq.size() != 1 || vq[0] !== 29'h1009ABCD) begin
         failures++;
         $display("FAIL trunc_recover: got n=%0d %h expected n=1 1009ABCD",
                  vq.size(), (vq.size() > 0) ? vq[0] : 29'd0);
      end
   endtask

   task automatic test_bad_preamble();
      clear_mon();
      fr.delete();
      fr.push_back(8'h55); fr.push_back(8'h55); fr.push_back(8'h12);
      for (int i = 0; i < 12; i++) fr.push_back(8'(i + 1));
      push16(16'h0800); fr.push_back(8'h01);
      push16(16'd5); push16(16'd0); push16(16'd1); push16(16'h7777);
      send_bytes(fr.size());
      end_frame(4);
      checks++;
      if (vq.size() != 0 || aq.size() != 0 || pe_seen) begin
         failures++;
         $display("FAIL bad_preamble: got v=%0d a=%0d pe=%b expected 0 0 0",
                  vq.size(), aq.size(), pe_seen);
      end
   endtask

   task automatic test_reset_midframe();
      clear_mon();
      begin_frame(16'h0800, 8'h01);
      push16(16'd3); push16(16'd0); push16(16'd3);
      push16(16'hAAAA); push16(16'hBBBB); push16(16'hCCCC);
      send_bytes(fr.size() - 3);
      @(negedge clk125);
      checks++;
      if (datain !== 29'h1003AAAA || packet_en !== 1'b1) begin
         failures++;
         $display("FAIL midframe_pre: got %h pe=%b expected 1003AAAA pe=1", datain, packet_en);
      end
      #1 sys_rst = 1'b1;
      #1;
      checks++;
      if ({datain, recv_en, packet_en, aux_data_in, aux_wr_en} !== 57'd0) begin
         failures++;
         $display("FAIL midframe_reset: got %h expected 0",
                  {datain, recv_en, packet_en, aux_data_in, aux_wr_en});
      end
      rx_dv = 1'b0;
      rxd   = 8'h00;
      repeat (2) @(negedge clk125);
      sys_rst = 1'b0;
      @(negedge clk125);
      clear_mon();
      begin_frame(16'h0800, 8'h01);
      push16(16'd4); push16(16'd0); push16(16'd1); push16(16'h0F0F);
      send_bytes(fr.size());
      end_frame(4);
      checks++;
      if (vq.size() != 1 || vq[0] !== 29'h10040F0F) begin
         failures++;
         $display("FAIL midframe_recover: got n=%0d %h expected n=1 10040F0F",
                  vq.size(), (vq.size() > 0) ? vq[0] : 29'd0);
      end
   endtask

   task automatic test_back_to_back();
      clear_mon();
      begin_frame(16'h0800, 8'h01);
      push16(16'd1); push16(16'd0); push16(16'd1); push16(16'h0001);
      send_bytes(fr.size());
      end_frame(1);
      begin_frame(16'h0800, 8'h81);
      fr.push_back(8'd1);
      push16(16'h00AB); push16(16'hCDEF);
      send_bytes(fr.size());
      end_frame(4);
      checks++;
      if (vq.size() != 1 || vq[0] !== 29'h10010001) begin
         failures++;
         $display("FAIL b2b_video: got n=%0d %h expected n=1 10010001",
                  vq.size(), (vq.size() > 0) ? vq[0] : 29'd0);
      end
      checks++;
      if (aq.size() != 1 || aq[0] !== 25'h0ABCDEF) begin
         failures++;
         $display("FAIL b2b_aux: got n=%0d %h expected n=1 0ABCDEF",
                  aq.size(), (aq.size() > 0) ? aq[0] : 25'd0);
      end
   endtask

   // Scenario sequence.
   initial begin
      test_reset();
      test_video();
      test_aux();
      test_reject();
      test_truncate();
      test_bad_preamble();
      test_reset_midframe();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
